// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage RISC-V pipeline control blocks.
package riscv_pipe_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hz_state_e;

    // The mem stage holds the younger result, so it wins over writeback.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (we_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
        else if (we_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
        else                                         return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   count <= '0;
        else if (clr)                 count <= '0;
        else if (inc && count != '1)  count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush/forward control for the 5-stage pipeline, with a post-reset
// drain window, a data-memory wait state and stall/flush event counters.
module pipeline_hazard_unit
    import riscv_pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemAccessM,
    input  logic             MemReadyM,
    input  logic             cnt_clear,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int               DW         = $clog2(DRAIN_CYCLES + 2);
    localparam hz_state_e        RST_STATE  = (DRAIN_CYCLES == 0) ? ST_RUN : ST_DRAIN;
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES);

    hz_state_e     state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          mem_miss, lw_stall, flush_inc;

    assign mem_miss = MemAccessM && !MemReadyM;
    assign lw_stall = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RST_STATE;
            drain_cnt <= DRAIN_INIT;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_DRAIN: begin
                drain_cnt_nxt = drain_cnt - 1'b1;
                if (drain_cnt <= DW'(1)) state_nxt = ST_RUN;
            end
            ST_RUN:      if (mem_miss)  state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (MemReadyM) state_nxt = ST_RUN;
            default:     state_nxt = ST_DRAIN;
        endcase
    end

    // Memory wait outranks everything; a taken branch outranks load-use.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (state == ST_DRAIN) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            if (state == ST_MEM_WAIT || mem_miss) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Only branch-driven flushes are counted, never drain flushes.
    assign flush_inc = (state == ST_RUN) && !mem_miss && PCSrcE;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (StallF),
        .clr   (cnt_clear),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (cnt_clear),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench: table vectors, directed corner sequences and random
// stimulus against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_unit;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [4:0] rdm, rdw;
        logic       regwm, regww, memacc, memrdy, clr;
    } in_t;

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe;
        logic [1:0] fa, fb;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic       clock = 1'b0, reset = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemAccessM, MemReadyM, cnt_clear;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [3:0] stall_count, flush_count;

    pipeline_hazard_unit #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM), .cnt_clear(cnt_clear),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    // Model state: remaining drain cycles, memory-wait flag, plain integer counts.
    int m_drain = 2;
    bit m_wait  = 1'b0;
    int m_stall = 0, m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input in_t i);
        if (rs == 0)                        return 2'b00;
        if (i.regwm && i.rdm == rs)         return 2'b10;
        if (i.regww && i.rdw == rs)         return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_memstall(input in_t i);
        return m_drain == 0 && (m_wait || (i.memacc && !i.memrdy));
    endfunction

    function automatic out_t model_out(input in_t i);
        out_t o = '0;
        if (m_drain > 0) begin
            o.fd = 1'b1; o.fe = 1'b1;
            return o;
        end
        o.fa = m_fwd(i.rs1e, i);
        o.fb = m_fwd(i.rs2e, i);
        if (m_memstall(i))
            {o.sf, o.sd, o.se, o.sm} = 4'hf;
        else if (i.pcsrc)
            {o.fd, o.fe} = 2'b11;
        else if (i.rsrc == 2'b01 && i.rde != 0 && (i.rde == i.rs1d || i.rde == i.rs2d))
            {o.sf, o.sd, o.fe} = 3'b111;
        return o;
    endfunction

    task automatic model_reset();
        m_drain = 2; m_wait = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step(input in_t i);
        out_t e;
        bit   br;
        if (!reset) begin
            model_reset();
            return;
        end
        e  = model_out(i);
        br = m_drain == 0 && !m_memstall(i) && i.pcsrc;
        if (i.clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (e.sf) m_stall = (m_stall >= 15) ? 15 : m_stall + 1;
            if (br)   m_flush = (m_flush >= 15) ? 15 : m_flush + 1;
        end
        if (m_drain > 0)                     m_drain--;
        else if (m_wait)                     m_wait = !i.memrdy;
        else if (i.memacc && !i.memrdy)      m_wait = 1'b1;
    endtask

    task automatic drive(input in_t i);
        Rs1D = i.rs1d; Rs2D = i.rs2d; Rs1E = i.rs1e; Rs2E = i.rs2e; RdE = i.rde;
        ResultSrcE = i.rsrc; PCSrcE = i.pcsrc; RdM = i.rdm; RdW = i.rdw;
        RegWriteM = i.regwm; RegWriteW = i.regww;
        MemAccessM = i.memacc; MemReadyM = i.memrdy; cnt_clear = i.clr;
    endtask

    // Called at posedge+1: drive, sample mid-cycle, compare, advance one clock.
    task automatic cycle(input in_t i, output out_t act);
        out_t e;
        drive(i);
        #4;
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
        e   = model_out(i);
        chk("outputs_vs_model", 32'(act), 32'(e));
        chk("stall_count_vs_model", 32'(stall_count), 32'(m_stall));
        chk("flush_count_vs_model", 32'(flush_count), 32'(m_flush));
        @(posedge clock);
        #1;
        model_step(i);
    endtask

    function automatic in_t idle();
        in_t i = '0;
        i.memrdy = 1'b1;
        return i;
    endfunction

    vec_t vecs[$];

    initial begin
        in_t  i;
        out_t act;
        vec_t v;
        int   tally;

        // 1: reset held 3 cycles, then exactly two drain flush cycles.
        drive(idle());
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) cycle(idle(), act);
        reset = 1'b1;
        tally = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(idle(), act);
            tally += int'(act.fe && act.fd);
        end
        chk("drain_flush_cycles", 32'(tally), 32'd2);
        chk("post_drain_flushE", 32'(act.fe), 32'd0);
        chk("stall_count_after_reset", 32'(stall_count), 32'd0);
        chk("flush_count_after_reset", 32'(flush_count), 32'd0);

        // 2: single load-use bubble bumps stall_count 0 -> 1.
        i = idle(); i.rsrc = 2'b01; i.rde = 5'd5; i.rs1d = 5'd5;
        cycle(i, act);
        chk("lw_stall_bubble", 32'({act.sf, act.sd, act.fe}), 32'b111);
        chk("lw_stall_count", 32'(stall_count), 32'd1);

        // Table vectors: each applied in RUN with memory idle.
        v.name = "lw_rs1";      v.i = idle(); v.i.rsrc = 2'b01; v.i.rde = 5;  v.i.rs1d = 5;
        v.o = '0; {v.o.sf, v.o.sd, v.o.fe} = 3'b111; vecs.push_back(v);
        v.name = "lw_x0";       v.i = idle(); v.i.rsrc = 2'b01; v.i.rde = 0;  v.i.rs1d = 0;
        v.o = '0; vecs.push_back(v);
        v.name = "lw_rs2";      v.i = idle(); v.i.rsrc = 2'b01; v.i.rde = 9;  v.i.rs2d = 9;
        v.o = '0; {v.o.sf, v.o.sd, v.o.fe} = 3'b111; vecs.push_back(v);
        v.name = "alu_no_stall"; v.i = idle(); v.i.rsrc = 2'b00; v.i.rde = 5; v.i.rs1d = 5;
        v.o = '0; vecs.push_back(v);
        v.name = "branch_over_lw"; v.i = idle(); v.i.rsrc = 2'b01; v.i.rde = 5; v.i.rs1d = 5; v.i.pcsrc = 1;
        v.o = '0; {v.o.fd, v.o.fe} = 2'b11; vecs.push_back(v);
        v.name = "fwd_m_over_w"; v.i = idle(); v.i.rs1e = 7; v.i.rdm = 7; v.i.regwm = 1; v.i.rdw = 7; v.i.regww = 1;
        v.o = '0; v.o.fa = 2'b10; vecs.push_back(v);
        v.name = "fwd_w";       v.i.regwm = 0; v.o = '0; v.o.fa = 2'b01; vecs.push_back(v);
        v.name = "fwd_rf";      v.i.rdw = 0;   v.o = '0; vecs.push_back(v);
        v.name = "fwd_split";   v.i = idle(); v.i.rs2e = 3; v.i.rdm = 3; v.i.regwm = 1; v.i.rs1e = 4; v.i.rdw = 4; v.i.regww = 1;
        v.o = '0; v.o.fa = 2'b01; v.o.fb = 2'b10; vecs.push_back(v);
        v.name = "fwd_x0";      v.i = idle(); v.i.rs1e = 0; v.i.rdm = 0; v.i.regwm = 1; v.i.rs2e = 0; v.i.rdw = 0; v.i.regww = 1;
        v.o = '0; vecs.push_back(v);

        i = idle(); i.clr = 1'b1;
        cycle(i, act);
        foreach (vecs[k]) begin
            cycle(vecs[k].i, act);
            chk(vecs[k].name, 32'(act), 32'(vecs[k].o));
        end

        // 3: branch + load-use counted once as a flush (table entry above).
        chk("flush_count_branch", 32'(flush_count), 32'd1);

        // 5: 4 miss cycles then ready: 5 stall cycles, coincident branch ignored.
        i = idle(); i.clr = 1'b1;
        cycle(i, act);
        tally = 0;
        for (int k = 0; k < 5; k++) begin
            i = idle(); i.memacc = 1'b1; i.memrdy = (k == 4); i.pcsrc = 1'b1;
            cycle(i, act);
            tally += int'(act.sf && act.sd && act.se && act.sm && !act.fe && !act.fd);
        end
        chk("mem_wait_stall_cycles", 32'(tally), 32'd5);
        chk("mem_wait_stall_count", 32'(stall_count), 32'd5);
        chk("mem_wait_flush_count", 32'(flush_count), 32'd0);
        cycle(idle(), act);
        chk("back_to_run", 32'({act.sf, act.sm}), 32'd0);

        // 6: saturation, clear, then async reset during a memory wait.
        for (int k = 0; k < 20; k++) begin
            i = idle(); i.memacc = 1'b1; i.memrdy = 1'b0;
            cycle(i, act);
        end
        chk("stall_count_saturated", 32'(stall_count), 32'd15);
        i = idle(); i.clr = 1'b1;
        cycle(i, act);
        chk("stall_count_cleared", 32'(stall_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            i = idle(); i.memacc = 1'b1; i.memrdy = 1'b0;
            cycle(i, act);
        end
        reset = 1'b0;
        #1;
        chk("async_reset_stall_drop", 32'({StallF, StallD, StallE, StallM}), 32'd0);
        chk("async_reset_drain_flush", 32'({FlushD, FlushE}), 32'b11);
        chk("async_reset_count", 32'(stall_count), 32'd0);
        model_reset();
        @(posedge clock); #1;
        cycle(idle(), act);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) cycle(idle(), act);

        // Random stimulus against the model; small register range for frequent matches.
        for (int k = 0; k < 400; k++) begin
            i = '0;
            i.rs1d = 5'($urandom_range(0, 3)); i.rs2d = 5'($urandom_range(0, 3));
            i.rs1e = 5'($urandom_range(0, 3)); i.rs2e = 5'($urandom_range(0, 3));
            i.rde  = 5'($urandom_range(0, 3)); i.rdm  = 5'($urandom_range(0, 3));
            i.rdw  = 5'($urandom_range(0, 3));
            i.rsrc   = 2'($urandom_range(0, 3));
            i.pcsrc  = ($urandom_range(0, 7) == 0);
            i.regwm  = 1'($urandom); i.regww = 1'($urandom);
            i.memacc = ($urandom_range(0, 3) == 0);
            i.memrdy = 1'($urandom);
            i.clr    = ($urandom_range(0, 31) == 0);
            cycle(i, act);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
